// File: rtl/ram_pkg.sv
// Shared encodings for the dual-port arbitrated scratch RAM.
package ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester that did not win last time is chosen.
module rr_arb2
    import ram_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last_grant,
    input  logic       en,
    output port_t      grant,
    output logic       grant_valid
);

    always_comb begin
        grant       = PORT_I;
        grant_valid = en && (req != 2'b00);
        if (req == 2'b11) begin
            grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (req[1]) begin
            grant = PORT_D;
        end
    end

endmodule

// File: rtl/ram_dual_arb.sv
// Single-array word RAM shared by an instruction (read-only) port and a data (byte-strobed) port,
// with round-robin arbitration, configurable wait states and an address-window error flag.
module ram_dual_arb
    import ram_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [31:0] d_addr,
    output logic [31:0] d_rdata,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_err
);

    localparam int         WORDS     = 2 ** DEPTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    logic [31:0] mem [WORDS];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    port_t       grant_q, grant_d;
    port_t       last_grant_q, last_grant_d;
    logic        i_ready_q, i_ready_d;
    logic        d_ready_q, d_ready_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_err_q, i_err_d;
    logic        d_err_q, d_err_d;

    port_t             arb_grant;
    logic              arb_valid;
    logic [31:0]       acc_addr;
    logic [DEPTH-1:0]  acc_idx;
    logic              acc_in_range;
    logic [31:0]       rd_word;
    logic [31:0]       acc_rdata;
    logic              access_now;
    logic              mem_we;
    logic              unused_addr_bits;

    rr_arb2 u_arb (
        .req         ({d_valid, i_valid}),
        .last_grant  (last_grant_q),
        .en          (state_q == ST_IDLE),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // Request fields are taken live from the granted port at the access edge, not latched at grant.
    assign acc_addr         = (grant_q == PORT_D) ? d_addr : i_addr;
    assign acc_idx          = acc_addr[DEPTH+1:2];
    assign acc_in_range     = (acc_addr[31:DEPTH+2] == BASE_ADDR[31:DEPTH+2]);
    assign unused_addr_bits = ^acc_addr[1:0];
    assign rd_word          = mem[acc_idx];
    assign acc_rdata        = acc_in_range ? rd_word : ERR_RDATA;
    assign access_now       = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    assign mem_we           = access_now && (grant_q == PORT_D) && acc_in_range;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        i_ready_d    = i_ready_q;
        d_ready_d    = d_ready_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_err_d      = i_err_q;
        d_err_d      = d_err_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d      = arb_grant;
                    last_grant_d = arb_grant;
                    cnt_d        = WAIT_INIT;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (grant_q == PORT_I) begin
                        i_ready_d = 1'b1;
                        i_rdata_d = acc_rdata;
                        i_err_d   = !acc_in_range;
                    end else begin
                        d_ready_d = 1'b1;
                        d_rdata_d = acc_rdata;
                        d_err_d   = !acc_in_range;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                i_ready_d = 1'b0;
                d_ready_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            grant_q      <= PORT_I;
            last_grant_q <= PORT_D;
            i_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            i_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
            i_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            i_ready_q    <= i_ready_d;
            d_ready_q    <= d_ready_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_err_q      <= i_err_d;
            d_err_q      <= d_err_d;
        end
    end

    // Array has no reset; the write is gated by state that is itself async-reset, so an abort blocks it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (d_wstrb[b]) begin
                    mem[acc_idx][8*b +: 8] <= d_wdata[8*b +: 8];
                end
            end
        end
    end

    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_err   = i_err_q;
    assign d_err   = d_err_q;

endmodule

// File: tb/tb_ram_dual_arb.sv
// Directed, table-driven bench for ram_dual_arb using three instances with different
// wait-state / base-address settings, plus hand-written multi-cycle sequences.
module tb_ram_dual_arb;

    logic        clk;
    logic        rstn     [3];
    logic        i_valid  [3];
    logic        i_ready  [3];
    logic [31:0] i_addr   [3];
    logic [31:0] i_rdata  [3];
    logic        i_err    [3];
    logic        d_valid  [3];
    logic        d_ready  [3];
    logic [31:0] d_addr   [3];
    logic [31:0] d_rdata  [3];
    logic [31:0] d_wdata  [3];
    logic [3:0]  d_wstrb  [3];
    logic        d_err    [3];

    int total_checks;
    int passed_checks;

    typedef struct {
        int          k;
        logic        is_d;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_edges;
    } vec_t;

    vec_t vecs [19];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dut0: no wait states, window at 0
    ram_dual_arb #(.DEPTH(8), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .resetn(rstn[0]),
        .i_valid(i_valid[0]), .i_ready(i_ready[0]), .i_addr(i_addr[0]),
        .i_rdata(i_rdata[0]), .i_err(i_err[0]),
        .d_valid(d_valid[0]), .d_ready(d_ready[0]), .d_addr(d_addr[0]),
        .d_rdata(d_rdata[0]), .d_wdata(d_wdata[0]), .d_wstrb(d_wstrb[0]), .d_err(d_err[0])
    );

    // dut1: three wait states, window at 0x8000_0000
    ram_dual_arb #(.DEPTH(8), .WAIT_STATES(3), .BASE_ADDR(32'h8000_0000)) dut1 (
        .clk(clk), .resetn(rstn[1]),
        .i_valid(i_valid[1]), .i_ready(i_ready[1]), .i_addr(i_addr[1]),
        .i_rdata(i_rdata[1]), .i_err(i_err[1]),
        .d_valid(d_valid[1]), .d_ready(d_ready[1]), .d_addr(d_addr[1]),
        .d_rdata(d_rdata[1]), .d_wdata(d_wdata[1]), .d_wstrb(d_wstrb[1]), .d_err(d_err[1])
    );

    // dut2: two wait states, used for the mid-transaction reset
    ram_dual_arb #(.DEPTH(8), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000)) dut2 (
        .clk(clk), .resetn(rstn[2]),
        .i_valid(i_valid[2]), .i_ready(i_ready[2]), .i_addr(i_addr[2]),
        .i_rdata(i_rdata[2]), .i_err(i_err[2]),
        .d_valid(d_valid[2]), .d_ready(d_ready[2]), .d_addr(d_addr[2]),
        .d_rdata(d_rdata[2]), .d_wdata(d_wdata[2]), .d_wstrb(d_wstrb[2]), .d_err(d_err[2])
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic check_all_zero(input int k, input string tag);
        check_output({tag, " i_ready"}, {31'h0, i_ready[k]}, 32'h0);
        check_output({tag, " d_ready"}, {31'h0, d_ready[k]}, 32'h0);
        check_output({tag, " i_rdata"}, i_rdata[k], 32'h0);
        check_output({tag, " d_rdata"}, d_rdata[k], 32'h0);
        check_output({tag, " i_err"}, {31'h0, i_err[k]}, 32'h0);
        check_output({tag, " d_err"}, {31'h0, d_err[k]}, 32'h0);
    endtask

    // One transaction on one port; returns the response and the number of edges from the first sampled valid.
    task automatic apply_stimulus(input int k, input logic is_d, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] wstrb,
                                  output logic [31:0] rdata, output logic err, output int edges);
        logic seen;
        @(negedge clk);
        if (is_d) begin
            d_addr[k]  = addr;
            d_wdata[k] = wdata;
            d_wstrb[k] = wstrb;
            d_valid[k] = 1'b1;
        end else begin
            i_addr[k]  = addr;
            i_valid[k] = 1'b1;
        end
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            seen = is_d ? d_ready[k] : i_ready[k];
        end
        if (!seen) begin
            check_output("ready timeout", 32'(edges), 32'hFFFF_FFFF);
        end
        rdata = is_d ? d_rdata[k] : i_rdata[k];
        err   = is_d ? d_err[k] : i_err[k];
        @(negedge clk);
        d_valid[k] = 1'b0;
        i_valid[k] = 1'b0;
        @(posedge clk);
        #1;
        check_output("ready one cycle", {31'h0, (is_d ? d_ready[k] : i_ready[k])}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          edges;
        int          got_port [4];
        int          got_cyc  [4];
        int          n_pulse;
        int          cyc;

        total_checks  = 0;
        passed_checks = 0;
        for (int k = 0; k < 3; k++) begin
            rstn[k]    = 1'b0;
            i_valid[k] = 1'b0;
            i_addr[k]  = 32'h0;
            d_valid[k] = 1'b0;
            d_addr[k]  = 32'h0;
            d_wdata[k] = 32'h0;
            d_wstrb[k] = 4'h0;
        end

        //            k  d     addr          wdata         strb  chk   exp_rdata     err  edges
        vecs[0]  = '{0, 1'b1, 32'h0000_0010, 32'hCAFE_BABE, 4'hF, 1'b0, 32'h0,        1'b0, 2};
        vecs[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'hCAFE_BABE, 1'b0, 2};
        vecs[2]  = '{0, 1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, 32'h0,        1'b0, 2};
        vecs[3]  = '{0, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1'b1, 32'h1122_3344, 1'b0, 2};
        vecs[4]  = '{0, 1'b1, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD, 1'b0, 2};
        vecs[5]  = '{0, 1'b0, 32'h0000_0022, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD, 1'b0, 2};
        vecs[6]  = '{0, 1'b1, 32'h0000_0020, 32'h5566_7788, 4'hA, 1'b1, 32'h11BB_33DD, 1'b0, 2};
        vecs[7]  = '{0, 1'b1, 32'h0000_0021, 32'h0,         4'h0, 1'b1, 32'h55BB_77DD, 1'b0, 2};
        vecs[8]  = '{0, 1'b0, 32'h0000_0400, 32'h0,         4'h0, 1'b1, 32'h0,        1'b1, 2};
        vecs[9]  = '{0, 1'b1, 32'h0000_0410, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0,        1'b1, 2};
        vecs[10] = '{0, 1'b1, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'hCAFE_BABE, 1'b0, 2};
        vecs[11] = '{1, 1'b1, 32'h8000_0000, 32'h1234_5678, 4'hF, 1'b0, 32'h0,        1'b0, 5};
        vecs[12] = '{1, 1'b1, 32'h8000_0400, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0,        1'b1, 5};
        vecs[13] = '{1, 1'b1, 32'h8000_0000, 32'h0,         4'h0, 1'b1, 32'h1234_5678, 1'b0, 5};
        vecs[14] = '{1, 1'b1, 32'h8000_03FC, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0,        1'b0, 5};
        vecs[15] = '{1, 1'b1, 32'h8000_03FC, 32'h0,         4'h0, 1'b1, 32'h0BAD_F00D, 1'b0, 5};
        vecs[16] = '{1, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 32'h0,        1'b1, 5};
        vecs[17] = '{2, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0,        1'b0, 4};
        vecs[18] = '{2, 1'b1, 32'h0000_0008, 32'h0,         4'h0, 1'b1, 32'hA5A5_A5A5, 1'b0, 4};

        #2;
        for (int k = 0; k < 3; k++) check_all_zero(k, "reset");
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rstn[k] = 1'b1;

        for (int v = 0; v < 19; v++) begin
            apply_stimulus(vecs[v].k, vecs[v].is_d, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, rd, er, edges);
            check_output($sformatf("vec%0d latency", v), 32'(edges), 32'(vecs[v].exp_edges));
            check_output($sformatf("vec%0d err", v), {31'h0, er}, {31'h0, vecs[v].exp_err});
            if (vecs[v].chk_rdata) begin
                check_output($sformatf("vec%0d rdata", v), rd, vecs[v].exp_rdata);
            end
        end

        // Wait-state countdown on dut1: cnt visible 3,2,1,0 then ready.
        @(negedge clk);
        d_addr[1]  = 32'h8000_0000;
        d_wstrb[1] = 4'h0;
        d_valid[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("ws cnt step%0d", i), {28'h0, dut1.cnt_q}, 32'(3 - i));
            check_output($sformatf("ws early ready%0d", i), {31'h0, d_ready[1]}, 32'h0);
        end
        @(posedge clk);
        #1;
        check_output("ws ready at edge5", {31'h0, d_ready[1]}, 32'h1);
        check_output("ws rdata", d_rdata[1], 32'h1234_5678);
        @(negedge clk);
        d_valid[1] = 1'b0;
        @(negedge clk);

        // Mid-transaction reset on dut2: the write of 0x5A5A5A5A must never land.
        @(negedge clk);
        d_addr[2]  = 32'h0000_0008;
        d_wdata[2] = 32'h5A5A_5A5A;
        d_wstrb[2] = 4'hF;
        d_valid[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rstn[2] = 1'b0;
        #1;
        check_all_zero(2, "midreset");
        d_valid[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn[2] = 1'b1;
        apply_stimulus(2, 1'b1, 32'h0000_0008, 32'h0, 4'h0, rd, er, edges);
        check_output("midreset word kept", rd, 32'hA5A5_A5A5);
        check_output("midreset latency", 32'(edges), 32'd4);
        check_output("midreset err", {31'h0, er}, 32'h0);

        // Contention on dut0 straight out of reset: I,D,I,D every 3 cycles.
        @(negedge clk);
        rstn[0] = 1'b0;
        @(negedge clk);
        rstn[0]    = 1'b1;
        i_addr[0]  = 32'h0000_0010;
        d_addr[0]  = 32'h0000_0020;
        d_wstrb[0] = 4'h0;
        i_valid[0] = 1'b1;
        d_valid[0] = 1'b1;
        n_pulse = 0;
        cyc     = 0;
        while (n_pulse < 4 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (i_ready[0] && d_ready[0]) begin
                check_output("both ready", 32'h1, 32'h0);
            end
            if (i_ready[0]) begin
                got_port[n_pulse] = 0;
                got_cyc[n_pulse]  = cyc;
                check_output("contend i_rdata", i_rdata[0], 32'hCAFE_BABE);
                n_pulse++;
            end else if (d_ready[0]) begin
                got_port[n_pulse] = 1;
                got_cyc[n_pulse]  = cyc;
                check_output("contend d_rdata", d_rdata[0], 32'h55BB_77DD);
                n_pulse++;
            end
        end
        @(negedge clk);
        i_valid[0] = 1'b0;
        d_valid[0] = 1'b0;
        check_output("contend pulses", 32'(n_pulse), 32'd4);
        if (n_pulse == 4) begin
            for (int i = 0; i < 4; i++) begin
                check_output($sformatf("contend order%0d", i), 32'(got_port[i]), 32'(i % 2));
            end
            check_output("contend first cycle", 32'(got_cyc[0]), 32'd2);
            for (int i = 1; i < 4; i++) begin
                check_output($sformatf("contend spacing%0d", i), 32'(got_cyc[i] - got_cyc[i-1]), 32'd3);
            end
        end
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/ram_dual_arb.md
Name: ram_dual_arb

Overview:
- Single-array word RAM with two picorv32-style slave ports: I (instruction, read-only) and D (data, read/write with byte strobes).
- Successor of the single-port scratch RAM. Adds:
  - parametrised depth, base address and wait states;
  - round-robin arbitration between the two ports;
  - address-range decode with an error flag.
- Sits between the microcoded core's fetch/data buses and on-chip memory.

Parameters:
- DEPTH, 8, log2 of word count (array = 2**DEPTH x 32 bits).
- WAIT_STATES, 0, extra cycles inserted before each array access (0..15).
- BASE_ADDR, 32'h0000_0000, base of the decoded window; must be aligned to 4*2**DEPTH.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- i_valid  in  1  I-port request
- i_ready  out  1  I-port one-cycle completion pulse
- i_addr  in  32  I-port byte address
- i_rdata  out  32  I-port read data, valid while i_ready=1
- i_err  out  1  I-port out-of-range flag, valid while i_ready=1
- d_valid  in  1  D-port request
- d_ready  out  1  D-port one-cycle completion pulse
- d_addr  in  32  D-port byte address
- d_rdata  out  32  D-port read data (old contents on write)
- d_wdata  in  32  D-port write data
- d_wstrb  in  4  D-port byte enables; 0 = read
- d_err  out  1  D-port out-of-range flag

Behaviour:
- Reset (resetn low, async):
  - state=IDLE, cnt=0, grant=I, last_grant=D (so I wins the first tie);
  - i_ready=d_ready=0, i_rdata=d_rdata=0, i_err=d_err=0;
  - array contents are not reset.
- Masters hold addr/wdata/wstrb/valid stable from assertion until the edge after their ready pulse. The block samples request fields at the ACCESS edge, not at grant time.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if neither valid, stay.
    - If exactly one valid, grant it.
    - If both valid, grant the port that is not last_grant.
    - On grant: cnt<=WAIT_STATES, last_grant<=granted port, state<=ACCESS.
  - ACCESS with cnt!=0: cnt<=cnt-1, stay.
  - ACCESS with cnt==0: perform the access for the granted port, assert that port's ready<=1, state<=RESP.
  - RESP: both readys<=0, state<=IDLE. Valids are ignored in RESP, so a still-high valid is never re-granted.
- Latency: ready is high in the cycle following edge (first sampled valid edge) + WAIT_STATES + 1.
- Throughput: one transaction per WAIT_STATES+3 cycles.
- Decode:
  - word index = addr[DEPTH+1:2];
  - in range iff addr[31:DEPTH+2] == BASE_ADDR[31:DEPTH+2];
  - addr[1:0] ignored.
- In-range access:
  - rdata <= array[index] (pre-write value);
  - for each set d_wstrb[b], array[index][8b+7:8b] <= d_wdata[8b+7:8b];
  - err <= 0.
- Out-of-range access: no array write, rdata <= 32'h0, err <= 1, ready still pulses (no hang).
- The non-granted port's ready, rdata and err hold their previous values; its ready stays 0.
- A request arriving while busy waits in IDLE arbitration. Equal load alternates I, D, I, D.
- Reset mid-transaction:
  - aborts immediately; if asserted before the ACCESS edge, no write occurs;
  - after release, pending valids are re-arbitrated with I first.
- d_wstrb=4'b0000 is a pure read. Partial strobes are legal for any pattern (including non-contiguous).

Decomposition:
- Shared package ram_pkg:
  - state encodings ST_IDLE/ST_ACCESS/ST_RESP;
  - port ids PORT_I=0/PORT_D=1;
  - ERR_RDATA=32'h0.
- One natural sub-module: rr_arb2, a two-requester round-robin arbiter.
  - Inputs: req[1:0], last_grant, en.
  - Outputs: grant id and grant_valid.
- Array, decode and FSM stay in ram_dual_arb.

Test Plan:
- WAIT_STATES=0, D writes 32'hCAFEBABE to 0x10 with wstrb=4'hF, then I reads 0x10 -> I read returns i_rdata=32'hCAFEBABE, i_err=0, d_ready high exactly 1 cycle, 3 cycles per transaction.
- Byte strobes: write 32'h11223344 to 0x20, then D writes 32'hAABBCCDD with wstrb=4'b0101 -> write returns d_rdata=32'h11223344, readback=32'h11BB33DD.
- Contention: i_valid and d_valid held high together for 4 transactions after reset -> grant order I,D,I,D; no ready pulse on the non-granted port.
- WAIT_STATES=3: single D read -> d_ready asserted 5 edges after the first sampled valid; cnt counts 3,2,1,0.
- Range: BASE_ADDR=32'h8000_0000, DEPTH=8, D write to 0x8000_0400 -> d_err=1, d_rdata=0, all array words unchanged; a read of 0x8000_03FC gives d_err=0.
- Reset mid-op: WAIT_STATES=2, D write to 0x8, resetn pulsed low during ACCESS before cnt==0 -> all outputs 0 immediately, word 0x8 unchanged, the next request is served normally.
